cond_flag_unit: RTL and testbench

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

---
 rtl/cond_flag_unit_pkg.sv | 29 ++
 rtl/cond_flag_unit_cond_check.sv | 43 ++++
 rtl/cond_flag_unit.sv | 73 +++++++
 tb/tb_cond_flag_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cond_flag_unit_pkg.sv
// Shared definitions for the ARM-style condition/flag logic.
// Condition codes and NZCV bit positions used by EX and branch units.
package cond_flag_unit_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_flag_unit_cond_check.sv
// Combinational ARM condition evaluator.
// Shared by the EX condition path and the branch unit.
module cond_check
  import cond_flag_unit_pkg::*;
#(
  parameter bit NV_PASS = 1'b0
) (
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = NV_PASS;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// ID->EX condition evaluation and NZCV flag register.
// ID sees EX flag results through a forwarding mux.
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000,
  parameter bit         NV_PASS   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       stall,
  input  logic       flush,
  input  logic       ex_s_bit,
  input  logic [3:0] alu_flags,
  output logic       ex_valid,
  output logic       ex_cond_pass,
  output logic [3:0] flags_q,
  output logic       carry_in
);

  logic       valid_q, valid_d;
  logic       pass_q, pass_d;
  logic [3:0] flags_d;
  logic [3:0] eval_flags;
  logic       ex_sets;
  logic       id_pass;

  // EX result is not yet architectural; ID must see it anyway
  assign ex_sets    = valid_q & pass_q & ex_s_bit;
  assign eval_flags = ex_sets ? alu_flags : flags_q;

  cond_check #(
    .NV_PASS(NV_PASS)
  ) u_cond_check (
    .cond(id_cond),
    .nzcv(eval_flags),
    .pass(id_pass)
  );

  always_comb begin
    valid_d = valid_q;
    pass_d  = pass_q;
    if (flush) begin
      valid_d = 1'b0;
      pass_d  = 1'b0;
    end else if (!stall) begin
      valid_d = id_valid;
      pass_d  = id_valid & id_pass;
    end
  end

  // Flush kills only the transfer; the EX flag write still retires
  assign flags_d = (ex_sets & !stall) ? alu_flags : flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pass_q  <= 1'b0;
      flags_q <= FLAGS_RST;
    end else begin
      valid_q <= valid_d;
      pass_q  <= pass_d;
      flags_q <= flags_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_cond_pass = pass_q;
  assign carry_in     = flags_q[FLAG_C];

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed vector bench for cond_flag_unit.
// Table rows, exhaustive cond x flags sweep, async reset cases.
module tb_cond_flag_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_cond;
  logic       stall;
  logic       flush;
  logic       ex_s_bit;
  logic [3:0] alu_flags;
  logic       ex_valid;
  logic       ex_cond_pass;
  logic [3:0] flags_q;
  logic       carry_in;

  int checks;
  int errors;

  cond_flag_unit #(
    .FLAGS_RST(4'b0000),
    .NV_PASS(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .id_cond(id_cond),
    .stall(stall),
    .flush(flush),
    .ex_s_bit(ex_s_bit),
    .alu_flags(alu_flags),
    .ex_valid(ex_valid),
    .ex_cond_pass(ex_cond_pass),
    .flags_q(flags_q),
    .carry_in(carry_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stl;
    logic       fls;
    logic       idv;
    logic [3:0] cond;
    logic       s;
    logic [3:0] alu;
    logic       ev;
    logic       ep;
    logic [3:0] ef;
  } vec_t;

  vec_t vecs[19];

  function automatic logic ref_cond(input logic [3:0] cc,
                                    input logic [3:0] f);
    logic n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'd0:  r = z;
      4'd1:  r = ~z;
      4'd2:  r = c;
      4'd3:  r = ~c;
      4'd4:  r = n;
      4'd5:  r = ~n;
      4'd6:  r = v;
      4'd7:  r = ~v;
      4'd8:  r = c && !z;
      4'd9:  r = !c || z;
      4'd10: r = (n ^ v) == 1'b0;
      4'd11: r = (n ^ v) == 1'b1;
      4'd12: r = !z && ((n ^ v) == 1'b0);
      4'd13: r = z || ((n ^ v) == 1'b1);
      4'd14: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic ev,
                         input logic ep, input logic [3:0] ef);
    chk({nm, ".ex_valid"}, {3'b0, ex_valid}, {3'b0, ev});
    chk({nm, ".ex_cond_pass"}, {3'b0, ex_cond_pass}, {3'b0, ep});
    chk({nm, ".flags_q"}, flags_q, ef);
    chk({nm, ".carry_in"}, {3'b0, carry_in}, {3'b0, ef[1]});
  endtask

  task automatic drive(input logic stl, input logic fls,
                       input logic idv, input logic [3:0] cc,
                       input logic s, input logic [3:0] alu);
    stall = stl; flush = fls; id_valid = idv;
    id_cond = cc; ex_s_bit = s; alu_flags = alu;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 4'h0, 0, 4'h0);

    //          stl fls idv cond   s  alu      ev ep flags
    vecs[0]  = '{0, 0, 1, 4'h0, 0, 4'b0000, 1, 0, 4'b0000};
    vecs[1]  = '{0, 0, 1, 4'hE, 0, 4'b0000, 1, 1, 4'b0000};
    vecs[2]  = '{0, 0, 1, 4'h0, 1, 4'b0100, 1, 1, 4'b0100};
    vecs[3]  = '{0, 0, 1, 4'h1, 1, 4'b0010, 1, 1, 4'b0010};
    vecs[4]  = '{0, 0, 1, 4'h3, 0, 4'b0000, 1, 0, 4'b0010};
    vecs[5]  = '{0, 0, 1, 4'h2, 1, 4'b1000, 1, 1, 4'b0010};
    vecs[6]  = '{0, 0, 1, 4'hA, 1, 4'b1001, 1, 1, 4'b1001};
    vecs[7]  = '{0, 0, 1, 4'h4, 1, 4'b1000, 1, 1, 4'b1000};
    vecs[8]  = '{0, 0, 0, 4'hE, 0, 4'b0000, 0, 0, 4'b1000};
    vecs[9]  = '{0, 1, 1, 4'hE, 0, 4'b0000, 0, 0, 4'b1000};
    vecs[10] = '{0, 0, 1, 4'hE, 0, 4'b0000, 1, 1, 4'b1000};
    vecs[11] = '{1, 0, 1, 4'h0, 1, 4'b1001, 1, 1, 4'b1000};
    vecs[12] = '{1, 0, 1, 4'h0, 1, 4'b1001, 1, 1, 4'b1000};
    vecs[13] = '{1, 0, 1, 4'h0, 1, 4'b1001, 1, 1, 4'b1000};
    vecs[14] = '{0, 0, 1, 4'hB, 1, 4'b1001, 1, 0, 4'b1001};
    vecs[15] = '{0, 0, 1, 4'hE, 0, 4'b0000, 1, 1, 4'b1001};
    vecs[16] = '{1, 1, 1, 4'hE, 1, 4'b0110, 0, 0, 4'b1001};
    vecs[17] = '{0, 0, 1, 4'hE, 0, 4'b0000, 1, 1, 4'b1001};
    vecs[18] = '{0, 1, 1, 4'hE, 1, 4'b0011, 0, 0, 4'b0011};

    #2;
    chk_all("reset", 0, 0, 4'b0000);
    step();
    #3 rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].stl, vecs[i].fls, vecs[i].idv,
            vecs[i].cond, vecs[i].s, vecs[i].alu);
      step();
      chk_all($sformatf("vec%0d", i),
              vecs[i].ev, vecs[i].ep, vecs[i].ef);
    end

    // Exhaustive sweep: load flags, then evaluate every cond unforwarded
    for (int f = 0; f < 16; f++) begin
      drive(0, 0, 1, 4'hE, 0, 4'h0);
      step();
      drive(0, 0, 0, 4'h0, 1, 4'(f));
      step();
      chk($sformatf("load_f%0d", f), flags_q, 4'(f));
      for (int c = 0; c < 16; c++) begin
        drive(0, 0, 1, 4'(c), 0, 4'h0);
        step();
        chk($sformatf("sweep_c%0d_f%0d", c, f),
            {3'b0, ex_cond_pass},
            {3'b0, ref_cond(4'(c), 4'(f))});
      end
    end

    // Async reset mid-cycle with flags all set
    drive(0, 0, 1, 4'hE, 0, 4'h0);
    step();
    drive(0, 0, 1, 4'hE, 1, 4'b1111);
    step();
    chk_all("pre_rst", 1, 1, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 4'b0000);
    #3 rst_n = 1'b1;
    // First edge after release: EX empty, so no flag write
    step();
    chk_all("post_rst", 1, 1, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
